// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
// Contents: FSM state encoding, data word width, and the access error check.
// No ports; imported by the interface, the responder and its RAM.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An access is bad if it is not word aligned or its word index lies
  // beyond the end of the RAM.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned       depth_words);
    logic [WORD_W-1:0] word_idx;
    word_idx = {2'b00, addr[WORD_W-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline MEM stage and the data memory.
// master: pipeline side (drives req_*); slave: memory side (drives req_ready,
// resp_*, stall).
interface dmem_responder_if;
  import mips_mem_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;
  logic              stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Latency: write and read both take effect on the rising edge; rdata is the
//   word at addr as of that edge (a write in the same edge is not forwarded).
// Ports: clk, we (write enable), addr (word index), wdata, rdata (registered).
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states.
// Latency: response pulse in the cycle after edge accept+WAIT_CYCLES.
// Backpressure: req_ready only in IDLE; stall holds the pipeline meanwhile.
// Ports: clk, rst (async, active-low), bus (dmem_responder_if.slave).
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;

  logic              cap_write;
  logic              cap_err;
  logic [AW-1:0]     cap_idx;
  logic [WORD_W-1:0] cap_wdata;

  logic              accept;
  logic              acc_write;
  logic              acc_err;
  logic [AW-1:0]     acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_write <= bus.req_write;
        cap_err   <= addr_err(bus.req_addr, DEPTH_WORDS);
        cap_idx   <= bus.req_addr[AW+1:2];
        cap_wdata <= bus.req_wdata;
      end
    end
  end

  // The RAM is touched on the edge entering RESP. With no wait states that
  // edge is the accepting edge itself, so the live request must be used.
  assign acc_write = (state == IDLE) ? bus.req_write : cap_write;
  assign acc_err   = (state == IDLE) ? addr_err(bus.req_addr, DEPTH_WORDS) : cap_err;
  assign acc_idx   = (state == IDLE) ? bus.req_addr[AW+1:2] : cap_idx;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;

  // The RAM has no reset, so clock edges while rst is low must not write it.
  assign ram_we = rst && (state_nxt == RESP) && acc_write && !acc_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = rst && (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && cap_err;
  assign bus.resp_rdata = ((state == RESP) && !cap_write && !cap_err) ? ram_rdata : '0;
  assign bus.stall      = rst && ((state == WAIT) || ((state == IDLE) && bus.req_valid));

endmodule
